// File: rtl/fifo_async_pack.sv
// fifo_async_pack: dual-clock FIFO, narrow write side, wide read side.
// R write words pack little-endian into one entry; gray pointers cross.
module fifo_async_pack #(
    parameter int DW_W  = 32,
    parameter int DW_R  = 64,
    parameter int DEPTH = 16,
    localparam int R      = DW_R / DW_W,
    localparam int AW     = $clog2(DEPTH),
    localparam int WCNT_W = $clog2(DEPTH * R + 1),
    localparam int RCNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk_w,
    input  logic              rst_n,
    input  logic              clk_r,
    input  logic              w_req,
    input  logic              w_flush,
    input  logic [DW_W-1:0]   data_i,
    output logic              full,
    output logic [WCNT_W-1:0] w_cnt,
    input  logic              r_req,
    output logic [DW_R-1:0]   data_o,
    output logic              empty,
    output logic [RCNT_W-1:0] r_cnt
);
    localparam int PCW = (R > 1) ? $clog2(R) : 1;
    localparam logic [AW:0] FULL_MASK = (AW + 1)'(3) << (AW - 1);
    localparam logic [PCW-1:0] LAST = PCW'(R - 1);

    function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--)
            b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [DW_R-1:0] mem [DEPTH];

    // write domain state
    logic [DW_R-1:0]   pack_buf;
    logic [PCW-1:0]    pack_cnt;
    logic [AW:0]       wbin, wgray;
    logic [AW:0]       rg_s1, rg_s2;

    logic              w_acc, f_acc, push, full_n;
    logic [DW_R-1:0]   pack_new, buf_n;
    logic [PCW-1:0]    cnt_n;
    logic [AW:0]       wbin_n, wgray_n, rbin_s, entries_w;
    logic [WCNT_W-1:0] w_cnt_n;

    // read domain state
    logic              rr1, rst_r_n;
    logic [AW:0]       rbin, rgray;
    logic [AW:0]       wg_s1, wg_s2;

    logic              r_acc, empty_n;
    logic [AW:0]       rbin_n, rgray_n;
    logic [RCNT_W-1:0] r_cnt_n;

    // packer lane insert, push decision and write-side flag lookahead
    always_comb begin
        w_acc    = w_req && !full;
        f_acc    = w_flush && !full;
        pack_new = pack_buf;
        if (w_acc)
            pack_new[int'(pack_cnt) * DW_W +: DW_W] = data_i;
        push  = 1'b0;
        cnt_n = pack_cnt;
        buf_n = pack_new;
        if (w_acc && pack_cnt == LAST)
            push = 1'b1;
        else if (f_acc && (w_acc || pack_cnt != '0))
            push = 1'b1;
        else if (w_acc)
            cnt_n = pack_cnt + PCW'(1);
        if (push) begin
            cnt_n = '0;
            buf_n = '0;
        end
        wbin_n    = wbin + {{AW{1'b0}}, push};
        wgray_n   = bin2gray(wbin_n);
        rbin_s    = gray2bin(rg_s2);
        full_n    = (wgray_n == (rg_s2 ^ FULL_MASK));
        entries_w = wbin_n - rbin_s;
        w_cnt_n   = WCNT_W'(entries_w) * WCNT_W'(R)
                  + WCNT_W'(cnt_n);
    end

    // storage write; no reset on the array
    always_ff @(posedge clk_w) begin
        if (rst_n && push)
            mem[wbin[AW-1:0]] <= pack_new;
    end

    // write pointer, packer, read-pointer sync and write flags
    always_ff @(posedge clk_w) begin
        if (!rst_n) begin
            pack_buf <= '0;
            pack_cnt <= '0;
            wbin     <= '0;
            wgray    <= '0;
            rg_s1    <= '0;
            rg_s2    <= '0;
            full     <= 1'b0;
            w_cnt    <= '0;
        end else begin
            pack_buf <= buf_n;
            pack_cnt <= cnt_n;
            wbin     <= wbin_n;
            wgray    <= wgray_n;
            rg_s1    <= rgray;
            rg_s2    <= rg_s1;
            full     <= full_n;
            w_cnt    <= w_cnt_n;
        end
    end

    // bring rst_n into the read clock domain
    always_ff @(posedge clk_r) begin
        rr1     <= rst_n;
        rst_r_n <= rr1;
    end

    // read pointer advance and read-side flag lookahead
    always_comb begin
        r_acc   = r_req && !empty;
        rbin_n  = rbin + {{AW{1'b0}}, r_acc};
        rgray_n = bin2gray(rbin_n);
        empty_n = (rgray_n == wg_s2);
        r_cnt_n = RCNT_W'(gray2bin(wg_s2) - rbin_n);
    end

    // read pointer, write-pointer sync, output register and read flags
    always_ff @(posedge clk_r) begin
        if (!rst_r_n) begin
            rbin   <= '0;
            rgray  <= '0;
            wg_s1  <= '0;
            wg_s2  <= '0;
            empty  <= 1'b1;
            r_cnt  <= '0;
            data_o <= '0;
        end else begin
            wg_s1 <= wgray;
            wg_s2 <= wg_s1;
            rbin  <= rbin_n;
            rgray <= rgray_n;
            empty <= empty_n;
            r_cnt <= r_cnt_n;
            if (r_acc)
                data_o <= mem[rbin[AW-1:0]];
        end
    end

endmodule

// File: tb/tb_fifo_async_pack.sv
// tb_fifo_async_pack: directed and scoreboard tests for fifo_async_pack.
// 32-bit writes, 64-bit reads, depth 4.
`timescale 1ns/1ps
module tb_fifo_async_pack;
    localparam int DW_W   = 32;
    localparam int DW_R   = 64;
    localparam int DEPTH  = 4;
    localparam int WCNT_W = $clog2(DEPTH * 2 + 1);
    localparam int RCNT_W = $clog2(DEPTH + 1);

    logic              clk_w   = 1'b0;
    logic              clk_r   = 1'b0;
    logic              rst_n   = 1'b0;
    logic              w_req   = 1'b0;
    logic              w_flush = 1'b0;
    logic              r_req   = 1'b0;
    logic [DW_W-1:0]   data_i  = '0;
    logic              full;
    logic              empty;
    logic [WCNT_W-1:0] w_cnt;
    logic [RCNT_W-1:0] r_cnt;
    logic [DW_R-1:0]   data_o;

    int tw_half = 5;
    int tr_half = 6;
    int n_vec   = 0;
    int n_bad   = 0;
    logic [DW_R-1:0] last_rd;
    logic [DW_R-1:0] q [$];

    fifo_async_pack #(
        .DW_W (DW_W),
        .DW_R (DW_R),
        .DEPTH(DEPTH)
    ) dut (
        .clk_w  (clk_w),
        .rst_n  (rst_n),
        .clk_r  (clk_r),
        .w_req  (w_req),
        .w_flush(w_flush),
        .data_i (data_i),
        .full   (full),
        .w_cnt  (w_cnt),
        .r_req  (r_req),
        .data_o (data_o),
        .empty  (empty),
        .r_cnt  (r_cnt)
    );

    initial forever #(tw_half) clk_w = ~clk_w;
    initial forever #(tr_half) clk_r = ~clk_r;

    initial begin
        #5000000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1);
    end

    task automatic wr(input logic [31:0] d, input logic fl);
        @(negedge clk_w);
        w_req   = 1'b1;
        w_flush = fl;
        data_i  = d;
        @(posedge clk_w);
        #1;
        w_req   = 1'b0;
        w_flush = 1'b0;
    endtask

    task automatic flush_only;
        @(negedge clk_w);
        w_flush = 1'b1;
        @(posedge clk_w);
        #1;
        w_flush = 1'b0;
    endtask

    task automatic rd;
        @(negedge clk_r);
        r_req = 1'b1;
        @(posedge clk_r);
        #1;
        r_req = 1'b0;
    endtask

    task automatic settle;
        repeat (5) @(posedge clk_w);
        repeat (5) @(posedge clk_r);
        #1;
    endtask

    task automatic wait_rcnt(input int n);
        int k;
        k = 0;
        while (int'(r_cnt) != n && k < 20) begin
            @(posedge clk_r);
            #1;
            k++;
        end
        n_vec++;
        if (int'(r_cnt) != n) begin
            n_bad++;
            $display("FAIL wait_rcnt: r_cnt=%0d want %0d", r_cnt, n);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (4) @(posedge clk_w);
        @(negedge clk_w);
        rst_n = 1'b1;
        repeat (2) @(posedge clk_r);
        #1;
        n_vec++;
        if (full !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_full: got %b want 0", full);
        end
        n_vec++;
        if (empty !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_empty: got %b want 1", empty);
        end
        n_vec++;
        if (w_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL rst_wcnt: got %0d want 0", w_cnt);
        end
        n_vec++;
        if (r_cnt !== 3'd0) begin
            n_bad++;
            $display("FAIL rst_rcnt: got %0d want 0", r_cnt);
        end
        n_vec++;
        if (data_o !== 64'h0) begin
            n_bad++;
            $display("FAIL rst_data: got %h want 0", data_o);
        end
    endtask

    task automatic test_pack_order;
        wr(32'h11111111, 1'b0);
        n_vec++;
        if (w_cnt !== 4'd1) begin
            n_bad++;
            $display("FAIL pack_wcnt1: got %0d want 1", w_cnt);
        end
        repeat (4) @(posedge clk_r);
        #1;
        n_vec++;
        if (empty !== 1'b1) begin
            n_bad++;
            $display("FAIL pack_partial_empty: got %b want 1", empty);
        end
        wr(32'h22222222, 1'b0);
        n_vec++;
        if (w_cnt !== 4'd2) begin
            n_bad++;
            $display("FAIL pack_wcnt2: got %0d want 2", w_cnt);
        end
        repeat (3) @(posedge clk_r);
        #1;
        n_vec++;
        if (empty !== 1'b0) begin
            n_bad++;
            $display("FAIL pack_empty_lat: got %b want 0", empty);
        end
        n_vec++;
        if (r_cnt !== 3'd1) begin
            n_bad++;
            $display("FAIL pack_rcnt: got %0d want 1", r_cnt);
        end
        rd;
        n_vec++;
        if (data_o !== 64'h22222222_11111111) begin
            n_bad++;
            $display("FAIL pack_data: got %h want 2222222211111111", data_o);
        end
        n_vec++;
        if (empty !== 1'b1) begin
            n_bad++;
            $display("FAIL pack_empty_after: got %b want 1", empty);
        end
    endtask

    task automatic test_full;
        logic [63:0] exp;
        settle;
        for (int i = 0; i < 8; i++)
            wr(32'(i), 1'b0);
        n_vec++;
        if (full !== 1'b1) begin
            n_bad++;
            $display("FAIL full_set: got %b want 1", full);
        end
        n_vec++;
        if (w_cnt !== 4'd8) begin
            n_bad++;
            $display("FAIL full_wcnt: got %0d want 8", w_cnt);
        end
        wr(32'hDEADBEEF, 1'b0);
        n_vec++;
        if (full !== 1'b1 || w_cnt !== 4'd8) begin
            n_bad++;
            $display("FAIL full_ignore: got full=%b w_cnt=%0d want 1/8", full, w_cnt);
        end
        wait_rcnt(4);
        for (int i = 0; i < 4; i++) begin
            rd;
            exp = {32'(2 * i + 1), 32'(2 * i)};
            n_vec++;
            if (data_o !== exp) begin
                n_bad++;
                $display("FAIL full_rd%0d: got %h want %h", i, data_o, exp);
            end
            if (i == 0) begin
                repeat (3) @(posedge clk_w);
                #1;
                n_vec++;
                if (full !== 1'b0) begin
                    n_bad++;
                    $display("FAIL full_clear: got %b want 0", full);
                end
            end
        end
        settle;
        n_vec++;
        if (empty !== 1'b1 || r_cnt !== 3'd0 || w_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL full_drain: got empty=%b r_cnt=%0d w_cnt=%0d want 1/0/0",
                     empty, r_cnt, w_cnt);
        end
    endtask

    task automatic test_flush;
        wr(32'hAAAA5555, 1'b1);
        n_vec++;
        if (w_cnt !== 4'd2) begin
            n_bad++;
            $display("FAIL flush_wcnt: got %0d want 2", w_cnt);
        end
        wait_rcnt(1);
        rd;
        n_vec++;
        if (data_o !== 64'h00000000_AAAA5555) begin
            n_bad++;
            $display("FAIL flush_data: got %h want 00000000aaaa5555", data_o);
        end
        flush_only;
        settle;
        n_vec++;
        if (empty !== 1'b1 || r_cnt !== 3'd0 || w_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL flush_noop: got empty=%b r_cnt=%0d w_cnt=%0d want 1/0/0",
                     empty, r_cnt, w_cnt);
        end
        wr(32'hC1C1C1C1, 1'b0);
        wr(32'hC2C2C2C2, 1'b1);
        settle;
        n_vec++;
        if (r_cnt !== 3'd1) begin
            n_bad++;
            $display("FAIL flush_complete_cnt: got %0d want 1", r_cnt);
        end
        rd;
        n_vec++;
        if (data_o !== 64'hC2C2C2C2_C1C1C1C1) begin
            n_bad++;
            $display("FAIL flush_complete: got %h want c2c2c2c2c1c1c1c1", data_o);
        end
        wr(32'h0000BBBB, 1'b0);
        flush_only;
        wait_rcnt(1);
        rd;
        n_vec++;
        if (data_o !== 64'h00000000_0000BBBB) begin
            n_bad++;
            $display("FAIL flush_alone: got %h want 000000000000bbbb", data_o);
        end
        last_rd = 64'h00000000_0000BBBB;
    endtask

    task automatic test_empty_read;
        settle;
        rd;
        n_vec++;
        if (data_o !== last_rd) begin
            n_bad++;
            $display("FAIL empty_rd_data: got %h want %h", data_o, last_rd);
        end
        n_vec++;
        if (r_cnt !== 3'd0 || empty !== 1'b1) begin
            n_bad++;
            $display("FAIL empty_rd_flags: got r_cnt=%0d empty=%b want 0/1", r_cnt, empty);
        end
        wr(32'hDDDDDDDD, 1'b0);
        wr(32'hEEEEEEEE, 1'b0);
        wait_rcnt(1);
        rd;
        n_vec++;
        if (data_o !== 64'hEEEEEEEE_DDDDDDDD) begin
            n_bad++;
            $display("FAIL empty_rd_ptr: got %h want eeeeeeeedddddddd", data_o);
        end
    endtask

    task automatic test_reset_mid;
        tr_half = 4;
        settle;
        for (int i = 0; i < 6; i++)
            wr(32'h30 + 32'(i), 1'b0);
        wait_rcnt(3);
        n_vec++;
        if (w_cnt !== 4'd6) begin
            n_bad++;
            $display("FAIL mid_wcnt_pre: got %0d want 6", w_cnt);
        end
        @(negedge clk_w);
        rst_n = 1'b0;
        @(negedge clk_w);
        rst_n = 1'b1;
        n_vec++;
        if (full !== 1'b0 || w_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL mid_wside: got full=%b w_cnt=%0d want 0/0", full, w_cnt);
        end
        repeat (3) @(posedge clk_r);
        #1;
        n_vec++;
        if (empty !== 1'b1 || r_cnt !== 3'd0) begin
            n_bad++;
            $display("FAIL mid_rside: got empty=%b r_cnt=%0d want 1/0", empty, r_cnt);
        end
        settle;
        n_vec++;
        if (full !== 1'b0 || w_cnt !== 4'd0 || empty !== 1'b1 || r_cnt !== 3'd0) begin
            n_bad++;
            $display("FAIL mid_settled: got full=%b w_cnt=%0d empty=%b r_cnt=%0d",
                     full, w_cnt, empty, r_cnt);
        end
        wr(32'h00005150, 1'b0);
        wr(32'h00005151, 1'b0);
        wait_rcnt(1);
        rd;
        n_vec++;
        if (data_o !== 64'h00005151_00005150) begin
            n_bad++;
            $display("FAIL mid_newdata: got %h want 0000515100005150", data_o);
        end
        settle;
        n_vec++;
        if (empty !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_no_old: got empty=%b want 1", empty);
        end
        tr_half = 6;
    endtask

    task automatic test_random(input logic [7:0] ph, input int tw, input int tr,
                               input int nw);
        bit wdone;
        tw_half = tw;
        tr_half = tr;
        wdone   = 1'b0;
        settle;
        fork
            begin
                logic [31:0] lane0;
                logic [31:0] d;
                int cnt;
                int seq;
                bit req;
                bit fl;
                bit done;
                bit pushed;
                cnt   = 0;
                seq   = 0;
                lane0 = '0;
                for (int i = 0; i < nw; i++) begin
                    @(negedge clk_w);
                    req = ($urandom_range(0, 9) < 6);
                    fl  = ($urandom_range(0, 9) < 2);
                    d   = {ph, 24'(seq)};
                    seq++;
                    w_req   = req;
                    w_flush = fl;
                    data_i  = d;
                    if (!full) begin
                        done = 1'b0;
                        if (req) begin
                            if (cnt == 1) begin
                                q.push_back({d, lane0});
                                cnt  = 0;
                                done = 1'b1;
                            end else begin
                                lane0 = d;
                                cnt   = 1;
                            end
                        end
                        if (fl && !done && cnt == 1) begin
                            q.push_back({32'h0, lane0});
                            cnt = 0;
                        end
                    end
                end
                @(negedge clk_w);
                w_req   = 1'b0;
                w_flush = 1'b0;
                pushed  = (cnt == 0);
                for (int k = 0; k < 200 && !pushed; k++) begin
                    @(negedge clk_w);
                    if (!full) begin
                        w_flush = 1'b1;
                        q.push_back({32'h0, lane0});
                        pushed = 1'b1;
                        @(negedge clk_w);
                        w_flush = 1'b0;
                    end
                end
                n_vec++;
                if (!pushed) begin
                    n_bad++;
                    $display("FAIL rnd_final_flush: got stuck full=%b want 0", full);
                end
                wdone = 1'b1;
            end
            begin
                logic [63:0] exp;
                int idle;
                int guard;
                bit rr;
                bit acc;
                idle  = 0;
                guard = 0;
                while (idle <= 10 && guard < 6000) begin
                    @(negedge clk_r);
                    guard++;
                    rr    = ($urandom_range(0, 3) != 0);
                    acc   = rr && !empty;
                    r_req = rr;
                    if (wdone && empty)
                        idle++;
                    else
                        idle = 0;
                    @(posedge clk_r);
                    #1;
                    r_req = 1'b0;
                    if (acc) begin
                        n_vec++;
                        if (q.size() == 0) begin
                            n_bad++;
                            $display("FAIL rnd_dup: got %h want no entry", data_o);
                        end else begin
                            exp = q.pop_front();
                            if (data_o !== exp) begin
                                n_bad++;
                                $display("FAIL rnd_data: got %h want %h", data_o, exp);
                            end
                        end
                    end
                end
                n_vec++;
                if (q.size() != 0 || guard >= 6000) begin
                    n_bad++;
                    $display("FAIL rnd_loss: got %0d left want 0", q.size());
                end
            end
        join
        q.delete();
    endtask

    initial begin
        test_reset;
        test_pack_order;
        test_full;
        test_flush;
        test_empty_read;
        test_reset_mid;
        test_random(8'hA1, 3, 9, 300);
        test_random(8'hB2, 9, 3, 300);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
